// File: rtl/alarm_fsm.sv
// Alarm arming controller: keypad code submit, exit/entry delays and wrong-code lockout.
// All outputs are registered and reflect the state chosen at the edge that sees the event.
//
// state      | meaning
// S_UNARMED  | disarmed, sensors ignored, state=00
// S_EXIT     | exit delay running after a good code, state=00
// S_ARMED    | armed and watching sensors, state=01
// S_ENTRY    | entry delay after a sensor trip, state=01
// S_ALARM    | alarm latched until a good code, state=10
module alarm_fsm #(
    parameter logic [3:0] CODE        = 4'b1010,
    parameter int         EXIT_DELAY  = 16,
    parameter int         ENTRY_DELAY = 16,
    parameter int         N_SENSORS   = 4,
    parameter int         MAX_FAILS   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           code,
    input  logic                 enter,
    input  logic [N_SENSORS-1:0] sensors,
    output logic [1:0]           state,
    output logic                 exit_pending,
    output logic                 entry_pending,
    output logic                 bad_code
);

    localparam int MAX_DELAY = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int CW        = $clog2(MAX_DELAY + 1);

    localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_DELAY - 1);
    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DELAY - 1);
    localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAILS);

    localparam logic [2:0] S_UNARMED = 3'd0;
    localparam logic [2:0] S_EXIT    = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_ENTRY   = 3'd3;
    localparam logic [2:0] S_ALARM   = 3'd4;

    logic [2:0]    fsm, fsm_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
    logic [2:0]    fails, fails_nxt, fails_plus;
    logic          enter_q;
    logic          enter_ok;
    logic          submit, good, bad;
    logic          fail_inc, limit_hit, tripped;
    logic [1:0]    state_nxt;
    logic          exit_nxt, entry_nxt;

    // enter_ok blocks a submit until enter has been seen low once after reset,
    // so a key held through reset is not taken as a fresh press.
    assign submit  = enter && !enter_q && enter_ok;
    assign good    = submit && (code == CODE);
    assign bad     = submit && (code != CODE);
    assign tripped = |sensors;

    assign cnt_dec    = (cnt == '0) ? cnt : (cnt - CW'(1));
    assign fails_plus = (fails >= FAIL_LIMIT) ? fails : (fails + 3'd1);
    assign fail_inc   = bad && ((fsm == S_ARMED) || (fsm == S_ENTRY));
    assign limit_hit  = fail_inc && (fails_plus == FAIL_LIMIT);

    always_comb begin
        fsm_nxt   = fsm;
        cnt_nxt   = cnt;
        fails_nxt = fail_inc ? fails_plus : fails;

        case (fsm)
            S_UNARMED: begin
                if (good) begin
                    fsm_nxt = S_EXIT;
                    cnt_nxt = EXIT_LOAD;
                end
            end
            S_EXIT: begin
                if (good)
                    fsm_nxt = S_UNARMED;
                else if (cnt == '0)
                    fsm_nxt = S_ARMED;
                else
                    cnt_nxt = cnt_dec;
            end
            S_ARMED: begin
                if (good)
                    fsm_nxt = S_UNARMED;
                else if (limit_hit)
                    fsm_nxt = S_ALARM;
                else if (tripped) begin
                    fsm_nxt = S_ENTRY;
                    cnt_nxt = ENTRY_LOAD;
                end
            end
            S_ENTRY: begin
                if (good)
                    fsm_nxt = S_UNARMED;
                else if (limit_hit)
                    fsm_nxt = S_ALARM;
                else if (cnt == '0)
                    fsm_nxt = S_ALARM;
                else
                    cnt_nxt = cnt_dec;
            end
            S_ALARM: begin
                if (good)
                    fsm_nxt = S_UNARMED;
            end
            default: begin
                fsm_nxt = S_UNARMED;
            end
        endcase

        if (fsm_nxt == S_UNARMED) begin
            fails_nxt = '0;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        state_nxt = 2'b00;
        exit_nxt  = 1'b0;
        entry_nxt = 1'b0;
        case (fsm_nxt)
            S_EXIT:  exit_nxt = 1'b1;
            S_ARMED: state_nxt = 2'b01;
            S_ENTRY: begin
                state_nxt = 2'b01;
                entry_nxt = 1'b1;
            end
            S_ALARM: state_nxt = 2'b10;
            default: state_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= S_UNARMED;
            cnt           <= '0;
            fails         <= '0;
            enter_q       <= 1'b0;
            enter_ok      <= 1'b0;
            state         <= 2'b00;
            exit_pending  <= 1'b0;
            entry_pending <= 1'b0;
            bad_code      <= 1'b0;
        end else begin
            fsm           <= fsm_nxt;
            cnt           <= cnt_nxt;
            fails         <= fails_nxt;
            enter_q       <= enter;
            enter_ok      <= enter_ok || !enter;
            state         <= state_nxt;
            exit_pending  <= exit_nxt;
            entry_pending <= entry_nxt;
            bad_code      <= bad;
        end
    end

endmodule

// File: tb/tb_alarm_fsm.sv
// Scoreboard bench for alarm_fsm: stimulus pushes hand-computed expected outputs,
// a monitor pops and compares them one step after each rising edge.
module tb_alarm_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code = 4'b0001;
    logic       enter = 1'b1;
    logic [3:0] sensors = 4'hF;
    logic [1:0] state;
    logic       exit_pending, entry_pending, bad_code;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    alarm_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .code         (code),
        .enter        (enter),
        .sensors      (sensors),
        .state        (state),
        .exit_pending (exit_pending),
        .entry_pending(entry_pending),
        .bad_code     (bad_code)
    );

    always #5 clk = ~clk;

    // Packed order: {state[1:0], exit_pending, entry_pending, bad_code}
    task automatic compare(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got {state,exit,entry,bad}=%b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic e, input logic [3:0] s,
                        input logic [1:0] st, input logic ex, input logic en,
                        input logic bd, input string nm);
        exp_t item;
        @(negedge clk);
        code    = c;
        enter   = e;
        sensors = s;
        item.exp  = {st, ex, en, bd};
        item.name = nm;
        sb.push_back(item);
    endtask

    task automatic do_arm();
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, "arm_start");
        for (int i = 0; i < 15; i++)
            step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, "exit_delay");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, "armed");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t item;
                item = sb.pop_front();
                compare(item.name, {state, exit_pending, entry_pending, bad_code}, item.exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rel;
        // Reset held with enter and all sensors high
        repeat (2) @(posedge clk);
        #1;
        compare("reset_values", {state, exit_pending, entry_pending, bad_code}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        rel.exp = 5'b0; rel.name = "rst_release_enter_high";
        sb.push_back(rel);
        for (int i = 0; i < 3; i++)
            step(4'b0001, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, "enter_held_after_rst");
        step(4'b0001, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "enter_low");

        // Arm with enter held high, sensors toggling during exit delay
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, "arm_t0");
        for (int i = 1; i <= 15; i++)
            step(4'b1010, 1'b1, (i % 2) ? 4'hF : 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, "exit_held");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, "armed_t16");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, "armed_idle");

        // Intrusion: entry delay, alarm, alarm latch, disarm
        step(4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b1, 1'b0, "trip");
        for (int i = 1; i <= 15; i++)
            step(4'b0000, 1'b0, (i == 3) ? 4'hF : 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, "entry_delay");
        step(4'b0000, 1'b0, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, "alarm");
        for (int i = 0; i < 3; i++)
            step(4'b0000, 1'b0, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, "alarm_hold");
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "disarm_alarm");
        step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "unarmed");

        // Disarm during entry delay at entry cycle 5
        do_arm();
        step(4'b0000, 1'b0, 4'b0001, 2'b01, 1'b0, 1'b1, 1'b0, "trip2");
        for (int i = 0; i < 3; i++)
            step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, "entry2");
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "disarm_entry");
        for (int i = 0; i < 14; i++)
            step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "no_alarm");

        // Lockout while armed
        do_arm();
        step(4'b0001, 1'b1, 4'h0, 2'b01, 1'b0, 1'b0, 1'b1, "bad1");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, "bad1_gap");
        step(4'b0010, 1'b1, 4'h0, 2'b01, 1'b0, 1'b0, 1'b1, "bad2");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, "bad2_gap");
        step(4'b0011, 1'b1, 4'h0, 2'b10, 1'b0, 1'b0, 1'b1, "bad3_lockout");
        step(4'b0000, 1'b0, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, "lockout_hold");
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "disarm_lockout");
        step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "unarmed2");

        // Wrong codes while unarmed never change state
        for (int i = 0; i < 3; i++) begin
            step(4'b0111, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, "bad_unarmed");
            step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "bad_unarmed_gap");
        end

        // Fail count cleared on disarm; good code beats a sensor trip
        do_arm();
        step(4'b0001, 1'b1, 4'h0, 2'b01, 1'b0, 1'b0, 1'b1, "bad_after_clear");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, "still_armed");
        step(4'b1010, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, "good_beats_sensor");
        step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "unarmed3");

        // Bad code and sensor together, then lockout from entry delay
        do_arm();
        step(4'b0001, 1'b1, 4'b0100, 2'b01, 1'b0, 1'b1, 1'b1, "bad_and_trip");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, "entry3");
        step(4'b0010, 1'b1, 4'h0, 2'b01, 1'b0, 1'b1, 1'b1, "bad_in_entry");
        step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, "entry3b");
        step(4'b0011, 1'b1, 4'h0, 2'b10, 1'b0, 1'b0, 1'b1, "lockout_in_entry");
        step(4'b1010, 1'b0, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, "lockout_hold2");
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "disarm3");
        step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, "unarmed4");

        // Asynchronous reset in the middle of the entry delay
        do_arm();
        step(4'b0000, 1'b0, 4'b1000, 2'b01, 1'b0, 1'b1, 1'b0, "trip4");
        for (int i = 0; i < 3; i++)
            step(4'b0000, 1'b0, 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, "entry4");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("async_reset", {state, exit_pending, entry_pending, bad_code}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        rel.exp = 5'b0; rel.name = "rst_release2";
        sb.push_back(rel);
        step(4'b1010, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, "arm_after_rst");
        step(4'b0000, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, "exit_after_rst");

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
